// File: rtl/wb_stage_rf.sv
// wb_stage_rf: write-back stage with an integrated register file.
// Holds one retiring instruction in a WB register, formats its result on
// capture, commits it into an NREGS x XLEN register file, serves two
// decode read ports with write-through bypass, and drives the forwarding path.
// Ports:
//   clk, rst                  clock, async active-high reset
//   in_valid / in_ready       MEM -> WB handshake
//   in_*                      instruction fields from MEM
//   hold                      freezes commit, the WB register, the RF and the counter
//   rs1/rs2_addr, rs1/rs2_data  decode read ports (combinational)
//   fwd_valid/fwd_rd/fwd_data   pending register write for execute
//   misalign_err              one-cycle pulse after a bad load commits
//   retired_count             committed-instruction counter
module wb_stage_rf #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned NREGS = 32,
  parameter int unsigned CNT_W = 32,
  localparam int unsigned AW   = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_reg_write,
  input  logic [AW-1:0]    in_rd,
  input  logic [1:0]       in_wb_sel,
  input  logic [XLEN-1:0]  in_alu_result,
  input  logic [XLEN-1:0]  in_load_data,
  input  logic [2:0]       in_load_funct3,
  input  logic [1:0]       in_addr_lo,
  input  logic [XLEN-1:0]  in_pc,
  input  logic [XLEN-1:0]  in_imm,
  input  logic             hold,
  input  logic [AW-1:0]    rs1_addr,
  input  logic [AW-1:0]    rs2_addr,
  output logic [XLEN-1:0]  rs1_data,
  output logic [XLEN-1:0]  rs2_data,
  output logic             fwd_valid,
  output logic [AW-1:0]    fwd_rd,
  output logic [XLEN-1:0]  fwd_data,
  output logic             misalign_err,
  output logic [CNT_W-1:0] retired_count
);

  // WB register
  logic            wb_valid;
  logic            wb_reg_write;
  logic [AW-1:0]   wb_rd;
  logic [XLEN-1:0] wb_data;
  logic            wb_err;

  logic [XLEN-1:0] rf [NREGS];

  logic            commit;
  logic            rf_we;
  logic            accept;
  logic [XLEN-1:0] fmt_data;
  logic            fmt_err;
  logic [7:0]      lane_b;
  logic [15:0]     lane_h;

  assign commit   = wb_valid && !hold;
  assign in_ready = !wb_valid || commit;
  assign accept   = in_valid && in_ready;
  assign rf_we    = commit && wb_reg_write && (wb_rd != '0) && !wb_err;

  assign fwd_valid = wb_valid && wb_reg_write && (wb_rd != '0) && !wb_err;
  assign fwd_rd    = wb_rd;
  assign fwd_data  = wb_data;

  // Result selection and load formatting, done before capture
  always_comb begin
    fmt_data = '0;
    fmt_err  = 1'b0;
    lane_b   = '0;
    lane_h   = in_addr_lo[1] ? in_load_data[31:16] : in_load_data[15:0];
    case (in_addr_lo)
      2'd0:    lane_b = in_load_data[7:0];
      2'd1:    lane_b = in_load_data[15:8];
      2'd2:    lane_b = in_load_data[23:16];
      default: lane_b = in_load_data[31:24];
    endcase
    case (in_wb_sel)
      2'b00: fmt_data = in_alu_result;
      2'b01: begin
        case (in_load_funct3)
          3'b000: fmt_data = {{(XLEN-8){lane_b[7]}}, lane_b};
          3'b100: fmt_data = XLEN'(lane_b);
          3'b001: begin
            if (in_addr_lo[0]) fmt_err = 1'b1;
            else               fmt_data = {{(XLEN-16){lane_h[15]}}, lane_h};
          end
          3'b101: begin
            if (in_addr_lo[0]) fmt_err = 1'b1;
            else               fmt_data = XLEN'(lane_h);
          end
          3'b010: begin
            if (in_addr_lo != 2'd0) fmt_err = 1'b1;
            else                    fmt_data = XLEN'(in_load_data[31:0]);
          end
          default: fmt_err = 1'b1;
        endcase
      end
      2'b10:   fmt_data = in_pc + XLEN'(4);
      default: fmt_data = in_imm;
    endcase
  end

  // WB register, error pulse and retire counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_valid      <= 1'b0;
      wb_reg_write  <= 1'b0;
      wb_rd         <= '0;
      wb_data       <= '0;
      wb_err        <= 1'b0;
      misalign_err  <= 1'b0;
      retired_count <= '0;
    end else begin
      misalign_err <= commit && wb_err;
      if (commit) retired_count <= retired_count + CNT_W'(1);
      if (accept) begin
        wb_valid     <= 1'b1;
        wb_reg_write <= in_reg_write;
        wb_rd        <= in_rd;
        wb_data      <= fmt_data;
        wb_err       <= fmt_err;
      end else if (commit) begin
        wb_valid <= 1'b0;
      end
    end
  end

  // Register file; x0 is never written because rf_we excludes rd 0
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(NREGS); i++) rf[i] <= '0;
    end else if (rf_we) begin
      rf[wb_rd] <= wb_data;
    end
  end

  // Read ports with write-through bypass of the committing result
  always_comb begin
    rs1_data = rf[rs1_addr];
    rs2_data = rf[rs2_addr];
    if (rf_we && rs1_addr == wb_rd) rs1_data = wb_data;
    if (rf_we && rs2_addr == wb_rd) rs2_data = wb_data;
    if (rs1_addr == '0) rs1_data = '0;
    if (rs2_addr == '0) rs2_data = '0;
  end

endmodule

// File: tb/tb_wb_stage_rf.sv
// Directed-vector bench for wb_stage_rf with hand-computed expectations.
module tb_wb_stage_rf;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned NREGS = 32;
  localparam int unsigned CNT_W = 32;
  localparam int unsigned AW    = 5;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic             in_reg_write;
  logic [AW-1:0]    in_rd;
  logic [1:0]       in_wb_sel;
  logic [XLEN-1:0]  in_alu_result;
  logic [XLEN-1:0]  in_load_data;
  logic [2:0]       in_load_funct3;
  logic [1:0]       in_addr_lo;
  logic [XLEN-1:0]  in_pc;
  logic [XLEN-1:0]  in_imm;
  logic             hold;
  logic [AW-1:0]    rs1_addr;
  logic [AW-1:0]    rs2_addr;
  logic [XLEN-1:0]  rs1_data;
  logic [XLEN-1:0]  rs2_data;
  logic             fwd_valid;
  logic [AW-1:0]    fwd_rd;
  logic [XLEN-1:0]  fwd_data;
  logic             misalign_err;
  logic [CNT_W-1:0] retired_count;

  int checks = 0;
  int errors = 0;

  wb_stage_rf #(.XLEN(XLEN), .NREGS(NREGS), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_reg_write(in_reg_write), .in_rd(in_rd), .in_wb_sel(in_wb_sel),
    .in_alu_result(in_alu_result), .in_load_data(in_load_data),
    .in_load_funct3(in_load_funct3), .in_addr_lo(in_addr_lo),
    .in_pc(in_pc), .in_imm(in_imm), .hold(hold),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(rs1_data), .rs2_data(rs2_data),
    .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
    .misalign_err(misalign_err), .retired_count(retired_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Present one instruction (caller is away from the rising edge)
  task automatic drive(input logic rw, input logic [AW-1:0] rd, input logic [1:0] sel,
                       input logic [31:0] alu, input logic [31:0] ld, input logic [2:0] f3,
                       input logic [1:0] off, input logic [31:0] pc);
    in_valid       = 1'b1;
    in_reg_write   = rw;
    in_rd          = rd;
    in_wb_sel      = sel;
    in_alu_result  = alu;
    in_load_data   = ld;
    in_load_funct3 = f3;
    in_addr_lo     = off;
    in_pc          = pc;
    in_imm         = 32'h0;
  endtask

  // Drive one instruction, take it on the next edge, and return at the next falling edge
  task automatic send(input logic rw, input logic [AW-1:0] rd, input logic [1:0] sel,
                      input logic [31:0] alu, input logic [31:0] ld, input logic [2:0] f3,
                      input logic [1:0] off, input logic [31:0] pc);
    drive(rw, rd, sel, alu, ld, f3, off, pc);
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
  endtask

  localparam logic [31:0] LDW = 32'h80F0_7F01;

  initial begin
    logic [AW-1:0] vrd [3];
    logic [1:0]    vsel [3];
    logic [31:0]   valu [3];

    rst = 1'b1; hold = 1'b0; rs1_addr = '0; rs2_addr = '0;
    drive(1'b0, '0, 2'b00, 0, 0, 3'b000, 2'b00, 0);
    in_valid = 1'b0;
    #12;
    chk("rst_ready", 64'(in_ready), 64'd1);
    chk("rst_fwd_valid", 64'(fwd_valid), 64'd0);
    chk("rst_fwd_data", 64'(fwd_data), 64'd0);
    chk("rst_count", 64'(retired_count), 64'd0);
    @(negedge clk); rst = 1'b0;
    @(negedge clk);

    // ALU write to x5; visible via bypass during commit cycle
    rs1_addr = 5'd5;
    send(1'b1, 5'd5, 2'b00, 32'h1234_5678, 0, 3'b000, 2'b00, 0);
    chk("alu_bypass", 64'(rs1_data), 64'h1234_5678);
    chk("alu_fwd_valid", 64'(fwd_valid), 64'd1);
    chk("alu_fwd_rd", 64'(fwd_rd), 64'd5);
    @(negedge clk);
    chk("alu_rf", 64'(rs1_data), 64'h1234_5678);
    chk("alu_count", 64'(retired_count), 64'd1);

    // Load formatting
    send(1'b1, 5'd10, 2'b01, 0, LDW, 3'b000, 2'd3, 0);
    chk("lb_off3", 64'(fwd_data), 64'hFFFF_FF80);
    send(1'b1, 5'd10, 2'b01, 0, LDW, 3'b100, 2'd0, 0);
    chk("lbu_off0", 64'(fwd_data), 64'h0000_0001);
    send(1'b1, 5'd10, 2'b01, 0, LDW, 3'b001, 2'd2, 0);
    chk("lh_off2", 64'(fwd_data), 64'hFFFF_80F0);
    send(1'b1, 5'd10, 2'b01, 0, LDW, 3'b101, 2'd2, 0);
    chk("lhu_off2", 64'(fwd_data), 64'h0000_80F0);
    send(1'b1, 5'd10, 2'b01, 0, LDW, 3'b010, 2'd0, 0);
    chk("lw_off0", 64'(fwd_data), 64'h80F0_7F01);

    // Misaligned LW into x7 after seeding x7
    rs1_addr = 5'd7;
    send(1'b1, 5'd7, 2'b00, 32'h77, 0, 3'b000, 2'd0, 0);
    send(1'b1, 5'd7, 2'b01, 0, LDW, 3'b010, 2'd1, 0);
    chk("mis_fwd_valid", 64'(fwd_valid), 64'd0);
    chk("mis_err_pre", 64'(misalign_err), 64'd0);
    chk("mis_no_bypass", 64'(rs1_data), 64'h77);
    @(negedge clk);
    chk("mis_err_pulse", 64'(misalign_err), 64'd1);
    chk("mis_x7_kept", 64'(rs1_data), 64'h77);
    chk("mis_count", 64'(retired_count), 64'd8);
    @(negedge clk);
    chk("mis_err_clear", 64'(misalign_err), 64'd0);

    // Back-to-back: x1=1, x1=2, x2=PC+4 of 0xFFFFFFFC
    vrd  = '{5'd1, 5'd1, 5'd2};
    vsel = '{2'b00, 2'b00, 2'b10};
    valu = '{32'd1, 32'd2, 32'd0};
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, vrd[i], vsel[i], valu[i], 0, 3'b000, 2'd0, 32'hFFFF_FFFC);
      chk($sformatf("b2b_ready%0d", i), 64'(in_ready), 64'd1);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    @(negedge clk);
    chk("b2b_ready_after", 64'(in_ready), 64'd1);
    chk("pc4_wrap_fwd", 64'(fwd_data), 64'd0);
    chk("pc4_fwd_valid", 64'(fwd_valid), 64'd1);
    @(negedge clk);
    rs1_addr = 5'd1; rs2_addr = 5'd2;
    #1;
    chk("b2b_x1", 64'(rs1_data), 64'd2);
    chk("b2b_x2", 64'(rs2_data), 64'd0);
    chk("b2b_count", 64'(retired_count), 64'd11);

    // Hold with pending x3 write
    rs1_addr = 5'd3;
    drive(1'b1, 5'd3, 2'b00, 32'h33, 0, 3'b000, 2'd0, 0);
    @(posedge clk);
    #1 in_valid = 1'b0; hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("hold_ready%0d", i), 64'(in_ready), 64'd0);
      chk($sformatf("hold_fwd%0d", i), 64'(fwd_valid), 64'd1);
      chk($sformatf("hold_x3_%0d", i), 64'(rs1_data), 64'd0);
      chk($sformatf("hold_cnt%0d", i), 64'(retired_count), 64'd11);
    end
    hold = 1'b0;
    #1;
    chk("unhold_bypass", 64'(rs1_data), 64'h33);
    chk("unhold_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    chk("unhold_x3", 64'(rs1_data), 64'h33);
    chk("unhold_count", 64'(retired_count), 64'd12);

    // Write to x0
    rs1_addr = 5'd0;
    send(1'b1, 5'd0, 2'b00, 32'hDEAD, 0, 3'b000, 2'd0, 0);
    chk("x0_fwd_valid", 64'(fwd_valid), 64'd0);
    chk("x0_read", 64'(rs1_data), 64'd0);
    @(negedge clk);
    chk("x0_read_after", 64'(rs1_data), 64'd0);
    chk("x0_count", 64'(retired_count), 64'd13);

    // Reset with a pending x4 write
    rs1_addr = 5'd5; rs2_addr = 5'd4;
    drive(1'b1, 5'd4, 2'b00, 32'h44, 0, 3'b000, 2'd0, 0);
    @(posedge clk);
    #1 in_valid = 1'b0;
    #1 rst = 1'b1;
    #1;
    chk("mrst_ready", 64'(in_ready), 64'd1);
    chk("mrst_fwd_valid", 64'(fwd_valid), 64'd0);
    chk("mrst_fwd_rd", 64'(fwd_rd), 64'd0);
    chk("mrst_fwd_data", 64'(fwd_data), 64'd0);
    chk("mrst_count", 64'(retired_count), 64'd0);
    chk("mrst_x5", 64'(rs1_data), 64'd0);
    @(negedge clk); rst = 1'b0;
    @(negedge clk); @(negedge clk);
    chk("mrst_x4_dropped", 64'(rs2_data), 64'd0);
    chk("mrst_count_after", 64'(retired_count), 64'd0);
    chk("mrst_err", 64'(misalign_err), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
